// File: rtl/fechadura_pkg.sv
// Shared definitions for the electronic lock: key codes, digit width and the
// password-configuration state encoding.
package fechadura_pkg;

   localparam int DIGITO_W = 4;

   localparam logic [DIGITO_W-1:0] TECLA_ASTERISCO = 4'hA;
   localparam logic [DIGITO_W-1:0] TECLA_CERQUILHA = 4'hB;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURA  = 2'd1,
      CONFIRMA = 2'd2,
      SALVA    = 2'd3
   } estado_cfg_t;

endpackage

// File: rtl/config_senha.sv
// Password configuration: after a debounced reset-button pulse, captures
// NUM_DIGITS keypad digits and commits them to senha on '#' confirmation.
module config_senha
   import fechadura_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter logic [NUM_DIGITS*DIGITO_W-1:0] DEFAULT_PIN = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rst_db,
   input  logic                           digito_valido,
   input  logic [DIGITO_W-1:0]            digito,
   output logic [NUM_DIGITS*DIGITO_W-1:0] senha,
   output logic                           modo_config,
   output logic                           senha_atualizada,
   output logic                           erro
);

   localparam int PIN_W = NUM_DIGITS*DIGITO_W;
   localparam int IDX_W = $clog2(NUM_DIGITS+1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS-1);
   // Abort on the edge that would make the timer reach TIMEOUT_CYCLES-1.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES-2);

   estado_cfg_t       estado;
   logic [IDX_W-1:0]  idx;
   logic [TMR_W-1:0]  timer;
   logic [PIN_W-1:0]  buffer;

   logic eh_digito;
   logic eh_cancel;
   logic eh_confirma;
   logic expirou;

   always_comb begin
      eh_digito   = digito_valido && (digito <= 4'd9);
      eh_cancel   = digito_valido && (digito == TECLA_ASTERISCO);
      eh_confirma = digito_valido && (digito == TECLA_CERQUILHA);
      expirou     = (timer == TMR_LAST);
      modo_config = (estado == CAPTURA) || (estado == CONFIRMA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado           <= IDLE;
         idx              <= '0;
         timer            <= '0;
         buffer           <= '0;
         senha            <= DEFAULT_PIN;
         senha_atualizada <= 1'b0;
         erro             <= 1'b0;
      end else begin
         senha_atualizada <= 1'b0;
         erro             <= 1'b0;
         case (estado)
            IDLE: begin
               if (rst_db) begin
                  estado <= CAPTURA;
                  idx    <= '0;
                  timer  <= '0;
                  buffer <= '0;
               end
            end
            CAPTURA: begin
               if (rst_db) begin
                  idx    <= '0;
                  timer  <= '0;
                  buffer <= '0;
               end else if (eh_digito) begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (idx == IDX_W'(i)) buffer[i*DIGITO_W +: DIGITO_W] <= digito;
                  end
                  idx   <= idx + IDX_W'(1);
                  timer <= '0;
                  if (idx == IDX_LAST) estado <= CONFIRMA;
               end else if (eh_cancel || eh_confirma || expirou) begin
                  erro   <= 1'b1;
                  estado <= IDLE;
                  idx    <= '0;
                  timer  <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            CONFIRMA: begin
               if (rst_db) begin
                  estado <= CAPTURA;
                  idx    <= '0;
                  timer  <= '0;
                  buffer <= '0;
               end else if (eh_confirma) begin
                  senha            <= buffer;
                  senha_atualizada <= 1'b1;
                  estado           <= SALVA;
                  idx              <= '0;
                  timer            <= '0;
               end else if (eh_cancel || expirou) begin
                  erro   <= 1'b1;
                  estado <= IDLE;
                  idx    <= '0;
                  timer  <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: begin
               // SALVA: commit already done on entry; rst_db is ignored here.
               estado <= IDLE;
            end
         endcase
      end
   end

endmodule
